// File: rtl/yu_core_pkg.sv
// Shared core definitions: word geometry, reset PC default and the fetch FSM encoding.
package yu_core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StDrain = 2'd1,
        StFault = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit boundary: redirect input, instruction-memory request/response and decode valid/ready.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_misaligned;

    modport master (
        input  redirect_valid, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, inst_misaligned
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, inst_misaligned
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO holding fetched {misaligned, pc, data} entries; flush empties it, and a push in
// the flush cycle lands as the sole surviving entry.
module fetch_buffer #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    count_q;
    logic [PW-1:0]    wr_idx;

    assign wr_idx = flush ? '0 : wr_q;
    assign count  = count_q;
    assign head   = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= push ? PW'(1) : '0;
            count_q <= push ? CW'(1) : '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, keeps at most one memory read in flight and buffers returned
// words for decode; redirects flush the buffer and retarget the PC.
module instruction_fetch_unit
    import yu_core_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = XLEN,
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned           BUF_DEPTH  = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    instruction_fetch_unit_if.master bus
);

    localparam int unsigned EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  outstanding_q, outstanding_d;

    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic [EW-1:0] push_data;
    logic          head_valid, pop, push, issue, accept, bad_target;

    assign head_valid = count != '0;
    assign pop        = head_valid & bus.inst_ready;
    assign bad_target = bus.redirect_valid & is_misaligned(bus.redirect_pc[1:0]);

    // A pop this cycle frees a slot, so a full buffer can still issue.
    assign issue = rst_n & (state_q == StFetch) & ~outstanding_q & ~bus.redirect_valid &
                   ((count < CW'(BUF_DEPTH)) | pop);

    // Responses are only kept in normal operation; DRAIN/FAULT swallow the stale one.
    assign accept = outstanding_q & bus.mem_rvalid & ~bus.redirect_valid & (state_q == StFetch);

    assign push      = accept | bad_target;
    assign push_data = bad_target ? {1'b1, bus.redirect_pc, {DATA_WIDTH{1'b0}}}
                                  : {1'b0, req_pc_q, bus.mem_rdata};

    fetch_buffer #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop & ~bus.redirect_valid),
        .flush     (bus.redirect_valid),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = issue | (outstanding_q & ~bus.mem_rvalid);

        if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            if (bad_target) begin
                state_d = StFault;
            end else if (outstanding_q && !bus.mem_rvalid) begin
                state_d = StDrain;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StDrain: if (outstanding_q && bus.mem_rvalid) state_d = StFetch;
                StFault: state_d = StFault;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.mem_req         = issue;
    assign bus.mem_addr        = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.inst_valid      = head_valid;
    assign bus.inst_misaligned = head_valid & head[EW-1];
    assign bus.inst_pc         = head_valid ? head[EW-2:DATA_WIDTH] : '0;
    assign bus.inst_data       = head_valid ? head[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random redirects/stalls/latencies,
// all checked against a queue-based model of delivered instructions.
module tb_instruction_fetch_unit;
    import yu_core_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    instruction_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;

    logic        drv_rst = 1'b0, drv_redir = 1'b0, drv_ready = 1'b1;
    logic [31:0] drv_rpc = '0;
    int          mem_lat = 1;

    // Bench memory: one pending read answered mem_lat cycles after its request.
    logic        pend = 1'b0;
    int          pend_due = 0;
    logic [31:0] pend_addr = '0;

    typedef struct packed {
        logic        mis;
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_out = 1'b0, m_kill = 1'b0, m_fault = 1'b0;
    logic [31:0] m_pc = '0, exp_fetch = RST_PC;

    logic        o_req, o_valid, o_mis;
    logic [31:0] o_addr, o_pc, o_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic rv, pop;
        ent_t e;
        @(posedge clk);
        #1;
        rst_n              = drv_rst;
        rv                 = pend && (cyc >= pend_due);
        bus.mem_rvalid     = rv;
        bus.mem_rdata      = rv ? mem_word(pend_addr) : $urandom();
        bus.redirect_valid = drv_redir;
        bus.redirect_pc    = drv_rpc;
        bus.inst_ready     = drv_ready;
        #1;
        o_req   = bus.mem_req;
        o_addr  = bus.mem_addr;
        o_valid = bus.inst_valid;
        o_pc    = bus.inst_pc;
        o_data  = bus.inst_data;
        o_mis   = bus.inst_misaligned;
        if (rv) pend = 1'b0;
        if (o_req) begin
            pend      = 1'b1;
            pend_due  = cyc + mem_lat;
            pend_addr = o_addr;
        end
        if (!drv_rst) begin
            check_eq("req_in_reset", o_req, 0);
            q.delete();
            m_out = 0; m_kill = 0; m_fault = 0;
            exp_fetch = RST_PC;
        end else begin
            check_eq("inst_valid", o_valid, q.size() != 0);
            if (q.size() != 0) begin
                check_eq("inst_pc", o_pc, q[0].pc);
                check_eq("inst_data", o_data, q[0].data);
                check_eq("inst_mis", o_mis, q[0].mis);
            end
            if (o_req) begin
                check_eq("mem_addr", o_addr, exp_fetch);
                if (m_out || m_fault || drv_redir) check_eq("req_blocked", o_req, 0);
                if (q.size() == DEPTH && !drv_ready) check_eq("req_full", o_req, 0);
            end
            pop = (q.size() != 0) && drv_ready;
            if (drv_redir) begin
                q.delete();
                if (drv_rpc[1:0] != 2'b00) begin
                    e = '{mis: 1'b1, pc: drv_rpc, data: 32'h0};
                    q.push_back(e);
                    m_fault = 1'b1;
                end else begin
                    m_fault = 1'b0;
                end
                exp_fetch = drv_rpc;
                if (m_out && !rv) m_kill = 1'b1;
                else m_out = 1'b0;
            end else begin
                if (pop) void'(q.pop_front());
                if (rv && m_out) begin
                    if (!m_kill) begin
                        e = '{mis: 1'b0, pc: m_pc, data: mem_word(m_pc)};
                        q.push_back(e);
                    end
                    m_out  = 1'b0;
                    m_kill = 1'b0;
                end
                if (o_req) begin
                    m_out     = 1'b1;
                    m_kill    = 1'b0;
                    m_pc      = exp_fetch;
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic wait_req();
        int i = 0;
        do begin
            cycle();
            i++;
        end while (!o_req && i < 20);
        check_eq("wait_req", o_req, 1);
    endtask

    task automatic wait_valid();
        int i = 0;
        do begin
            cycle();
            i++;
        end while (!o_valid && i < 20);
        check_eq("wait_valid", o_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, nval;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_rvalid     = 1'b0;
        bus.mem_rdata      = '0;
        bus.inst_ready     = 1'b0;

        // Reset values, then 1-cycle memory with decode always ready.
        drv_rst = 1'b0;
        repeat (2) cycle();
        check_eq("rst_addr", o_addr, RST_PC);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_pc", o_pc, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_mis", o_mis, 0);
        drv_rst = 1'b1; drv_ready = 1'b1; mem_lat = 1;
        cycle(); check_eq("t1_c1_req", o_req, 1); check_eq("t1_c1_addr", o_addr, 32'h0);
        cycle(); check_eq("t1_c2_req", o_req, 0);
        cycle(); check_eq("t1_c3_req", o_req, 1); check_eq("t1_c3_addr", o_addr, 32'h4);
        check_eq("t1_c3_valid", o_valid, 1); check_eq("t1_c3_pc", o_pc, 32'h0);
        cycle();
        cycle(); check_eq("t1_c5_req", o_req, 1); check_eq("t1_c5_addr", o_addr, 32'h8);

        // Back-pressure fills the buffer; the first pop lets the next request out.
        drv_rst = 1'b0; cycle();
        drv_rst = 1'b1; drv_ready = 1'b0; nreq = 0;
        repeat (8) begin cycle(); nreq += int'(o_req); end
        check_eq("t2_nreq", nreq, 2);
        check_eq("t2_full_valid", o_valid, 1);
        mem_lat = 4; drv_ready = 1'b1;
        cycle(); check_eq("t2_pop_req", o_req, 1); check_eq("t2_pop_addr", o_addr, 32'h8);
        check_eq("t2_pop_pc", o_pc, 32'h0);

        // Redirect while 0x8 is in flight: its late response must be discarded.
        drv_redir = 1'b1; drv_rpc = 32'h100; cycle(); drv_redir = 1'b0; mem_lat = 1;
        repeat (2) begin cycle(); check_eq("t3_drain_req", o_req, 0); end
        cycle(); check_eq("t3_rv_req", o_req, 0);
        cycle(); check_eq("t3_req", o_req, 1); check_eq("t3_addr", o_addr, 32'h100);
        check_eq("t3_novalid", o_valid, 0);
        wait_valid(); check_eq("t3_pc", o_pc, 32'h100);

        // Redirect in the same cycle as the response: no drain, immediate refetch.
        wait_req();
        drv_redir = 1'b1; drv_rpc = 32'h300; cycle(); drv_redir = 1'b0;
        cycle(); check_eq("t4_req", o_req, 1); check_eq("t4_addr", o_addr, 32'h300);
        wait_valid(); check_eq("t4_pc", o_pc, 32'h300);

        // Misaligned target: a single fault marker and no fetch until the next redirect.
        drv_ready = 1'b0;
        drv_redir = 1'b1; drv_rpc = 32'h102; cycle(); drv_redir = 1'b0;
        cycle();
        check_eq("t5_valid", o_valid, 1); check_eq("t5_mis", o_mis, 1);
        check_eq("t5_pc", o_pc, 32'h102); check_eq("t5_data", o_data, 0);
        drv_ready = 1'b1; nreq = 0; nval = 0;
        repeat (6) begin cycle(); nreq += int'(o_req); nval += int'(o_valid); end
        check_eq("t5_nreq", nreq, 0);
        check_eq("t5_nval", nval, 1);
        drv_redir = 1'b1; drv_rpc = 32'h200; cycle(); drv_redir = 1'b0;
        cycle(); check_eq("t5_resume_req", o_req, 1); check_eq("t5_resume_addr", o_addr, 32'h200);

        // Reset during an outstanding read whose response lands inside reset.
        mem_lat = 3;
        wait_req();
        drv_rst = 1'b0; repeat (3) cycle();
        mem_lat = 1; drv_rst = 1'b1;
        cycle(); check_eq("t6_req", o_req, 1); check_eq("t6_addr", o_addr, RST_PC);
        check_eq("t6_novalid", o_valid, 0);
        wait_valid(); check_eq("t6_pc", o_pc, RST_PC);

        // Random stalls, latencies and redirects (including misaligned and near-wrap targets).
        repeat (1500) begin
            drv_ready = ($urandom_range(0, 3) != 0);
            mem_lat   = $urandom_range(1, 3);
            drv_redir = ($urandom_range(0, 15) == 0);
            if (drv_redir) begin
                if ($urandom_range(0, 7) == 0) drv_rpc = 32'hFFFF_FFF8;
                else drv_rpc = $urandom() & 32'h0000_0FFC;
                if ($urandom_range(0, 4) == 0) drv_rpc[1:0] = 2'($urandom_range(1, 3));
            end
            cycle();
        end
        drv_redir = 1'b0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
